multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle FSM controller that sequences the shared register-file/ALU datapath for an RV32 subset: ADDI, ADD, SUB, AND, OR, LW, SW, BEQ, BNE.
- Accepts one instruction at a time from fetch over a valid/ready handshake.
- Drives register addresses, immediate, ALU controls, write enable, memory request and PC update.
- Counts retired instructions and traps on illegal encodings or a memory timeout.

Parameters:
- A_WIDTH, 5, register address width.
- D_WIDTH, 32, data/instruction/immediate width.
- MEM_TIMEOUT, 255, maximum MEM-state cycles without mem_ack before trapping; must be ≥1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- instr_valid  in  1  fetch presents instr.
- instr  in  D_WIDTH  instruction word.
- instr_ready  out  1  controller accepts instr this cycle.
- eq  in  1  ALU equality flag from datapath.
- mem_ack  in  1  data memory completed request.
- mem_req  out  1  data memory request, held until ack.
- mem_we  out  1  1 = store, 0 = load; valid while mem_req.
- rs1, rs2, rd  out  A_WIDTH each  register addresses.
- reg_write  out  1  register-file write enable.
- wb_sel  out  1  write-back source: 0 = ALU, 1 = memory.
- alu_src  out  1  ALU operand 2: 0 = register, 1 = immediate.
- alu_ctrl  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
- imm_op  out  D_WIDTH  sign-extended immediate (I/S/B format).
- pc_en  out  1  one-cycle PC update pulse; equals retire.
- pc_src  out  1  PC source: 0 = PC+4, 1 = PC+imm_op.
- illegal  out  1  sticky trap flag.
- instret  out  32  retired-instruction count.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset state is FETCH.
- Reset: state = FETCH, IR = 0, instret = 0, illegal = 0, timeout counter = 0. Every output is 0 while rst is high; instr_ready is gated by !rst.
- Reset mid-operation aborts the instruction immediately. No write or retire occurs, and mem_req drops asynchronously.
- FETCH: instr_ready = 1. On instr_valid && instr_ready, latch IR and go to DECODE; otherwise stay.
- DECODE (1 cycle):
  - rs1, rs2, rd, imm_op are driven from IR from DECODE through WB.
  - Unsupported opcode/funct3/funct7 -> TRAP; otherwise -> EXEC.
- EXEC (1 cycle): alu_src and alu_ctrl are driven per instruction class.
  - OP / OP-IMM -> WB.
  - LOAD / STORE -> MEM.
  - BRANCH: pc_en = 1; pc_src = eq for BEQ, !eq for BNE; -> FETCH.
- Per-class controls:
  - ADDI: alu_src = 1, ADD, I-immediate.
  - ADD / SUB / AND / OR: alu_src = 0, matching alu_ctrl.
  - LW: alu_src = 1, ADD, I-immediate. SW: alu_src = 1, ADD, S-immediate.
  - BEQ / BNE: alu_src = 0, SUB, B-immediate.
- MEM: mem_req = 1; mem_we = 1 for SW.
  - Counter increments each cycle without mem_ack.
  - On mem_ack: SW -> pc_en = 1, FETCH; LW -> WB with wb_sel = 1.
  - Counter reaching MEM_TIMEOUT without ack -> TRAP.
  - mem_ack outside MEM is ignored.
- WB (1 cycle): reg_write = (rd != 0), so rd = x0 never writes; pc_en = 1; pc_src = 0; -> FETCH.
- TRAP:
  - illegal = 1, sticky until rst.
  - instr_ready, reg_write, mem_req, pc_en all held at 0.
  - Trapped instruction is not retired.
- Latency from accept cycle to retire:
  - ALU ops: 3 cycles after accept.
  - Branch: 2 cycles.
  - Load/store: 3 + mem wait cycles (including the WB cycle for LW).
- instret: +1 on every pc_en cycle; wraps 0xFFFFFFFF -> 0.
- All outputs are combinational from state/IR except instret and illegal, which are registered.

Decomposition:
- Package ctrl_pkg holds:
  - state enum.
  - Opcode constants OP 0110011, OP_IMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
  - alu_ctrl encodings.
- Sub-module imm_gen: combinational I/S/B immediate extraction and sign extension from IR.

Test Plan:
- Reset, then addi x1,x0,5 (0x00500093) with instr_valid held -> instr_ready drops after accept; EXEC shows alu_src = 1, alu_ctrl = 00, imm_op = 5; WB shows reg_write = 1, rd = 1; pc_en pulses; instret = 1.
- sub x3,x1,x2 (0x402081B3) -> alu_ctrl = 01, alu_src = 0; reg_write in WB. Then add x0,x1,x2 (0x00208033) -> reg_write stays 0, instret still increments.
- bne x1,x2,8 (0x00209463):
  - eq = 0 -> pc_src = 1, imm_op = 8, pc_en in EXEC, no reg_write.
  - Repeat with eq = 1 -> pc_src = 0.
- lw x5,4(x1) (0x0040A283) with mem_ack after 3 cycles -> mem_req high exactly 3 cycles, mem_we = 0; then WB with wb_sel = 1, reg_write = 1, rd = 5.
- sw with mem_ack never asserted, MEM_TIMEOUT = 4 -> TRAP after 4 MEM cycles; illegal = 1; instr_ready stays 0; instret unchanged.
- 0xFFFFFFFF -> TRAP from DECODE.
- Assert rst mid-MEM -> all outputs 0 immediately; after release, FETCH with instr_ready = 1, illegal = 0, instret = 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared types and constants for the multi-cycle RV32-subset
//               controller: FSM state encoding, opcode constants, ALU
//               operation encodings, decoded-instruction class and the
//               immediate-format selector, plus the instruction decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  typedef enum logic [3:0] {
    INS_ILL  = 4'd0,
    INS_ADDI = 4'd1,
    INS_ADD  = 4'd2,
    INS_SUB  = 4'd3,
    INS_AND  = 4'd4,
    INS_OR   = 4'd5,
    INS_LW   = 4'd6,
    INS_SW   = 4'd7,
    INS_BEQ  = 4'd8,
    INS_BNE  = 4'd9
  } ins_e;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2
  } imm_e;

  // Maps opcode/funct3/funct7 to an instruction class; anything outside the
  // supported subset comes back as INS_ILL.
  function automatic ins_e decode_ins(input logic [6:0] opc,
                                      input logic [2:0] f3,
                                      input logic [6:0] f7);
    ins_e ins;
    ins = INS_ILL;
    case (opc)
      OPC_OP: begin
        if (f3 == 3'b000 && f7 == 7'b0000000)      ins = INS_ADD;
        else if (f3 == 3'b000 && f7 == 7'b0100000) ins = INS_SUB;
        else if (f3 == 3'b111 && f7 == 7'b0000000) ins = INS_AND;
        else if (f3 == 3'b110 && f7 == 7'b0000000) ins = INS_OR;
      end
      OPC_OP_IMM: if (f3 == 3'b000) ins = INS_ADDI;
      OPC_LOAD:   if (f3 == 3'b010) ins = INS_LW;
      OPC_STORE:  if (f3 == 3'b010) ins = INS_SW;
      OPC_BRANCH: begin
        if (f3 == 3'b000)      ins = INS_BEQ;
        else if (f3 == 3'b001) ins = INS_BNE;
      end
      default: ins = INS_ILL;
    endcase
    return ins;
  endfunction

endpackage
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational immediate extraction (I/S/B formats) with sign
//               extension to D_WIDTH.
// Ports       : ir_hi - instruction bits [31:20]
//               ir_lo - instruction bits [11:7]
//               sel   - immediate format select
//               imm   - sign-extended immediate
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
  import ctrl_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic [11:0]        ir_hi,
  input  logic [4:0]         ir_lo,
  input  imm_e               sel,
  output logic [D_WIDTH-1:0] imm
);

  // All three formats fit in 13 bits (B-format carries an implicit zero LSB).
  logic [12:0] w_raw;

  always_comb begin
    w_raw = '0;
    case (sel)
      IMM_I:   w_raw = {ir_hi[11], ir_hi};
      IMM_S:   w_raw = {ir_hi[11], ir_hi[11:5], ir_lo};
      IMM_B:   w_raw = {ir_hi[11], ir_lo[0], ir_hi[10:5], ir_lo[4:1], 1'b0};
      default: w_raw = '0;
    endcase
    imm = {{(D_WIDTH-13){w_raw[12]}}, w_raw};
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle FSM controller sequencing a shared register-file /
//               ALU datapath for ADDI, ADD, SUB, AND, OR, LW, SW, BEQ, BNE.
//               One instruction is accepted at a time over valid/ready;
//               retired instructions are counted and illegal encodings or a
//               memory timeout raise a sticky trap.
// Ports       : clk, rst              - clock, async active-high reset
//               instr_valid/instr/instr_ready - fetch handshake
//               eq, mem_ack           - datapath equality flag, memory done
//               mem_req, mem_we       - data memory request / store select
//               rs1, rs2, rd          - register addresses
//               reg_write, wb_sel     - write enable, write-back source
//               alu_src, alu_ctrl     - ALU operand-2 source and operation
//               imm_op                - sign-extended immediate
//               pc_en, pc_src         - PC update pulse and source
//               illegal, instret      - sticky trap flag, retire counter
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int A_WIDTH     = 5,
  parameter int D_WIDTH     = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  input  logic [D_WIDTH-1:0] instr,
  output logic               instr_ready,
  input  logic               eq,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] rs1,
  output logic [A_WIDTH-1:0] rs2,
  output logic [A_WIDTH-1:0] rd,
  output logic               reg_write,
  output logic               wb_sel,
  output logic               alu_src,
  output logic [1:0]         alu_ctrl,
  output logic [D_WIDTH-1:0] imm_op,
  output logic               pc_en,
  output logic               pc_src,
  output logic               illegal,
  output logic [31:0]        instret
);

  // Counter must be able to hold MEM_TIMEOUT itself.
  localparam int CW = $clog2(MEM_TIMEOUT + 1);

  state_e             r_state;
  logic [D_WIDTH-1:0] r_ir;
  logic [CW-1:0]      r_cnt;
  logic [31:0]        r_instret;
  logic               r_illegal;

  ins_e               w_ins;
  imm_e               w_imm_sel;
  logic [D_WIDTH-1:0] w_imm;
  logic               w_active;

  assign w_ins = decode_ins(r_ir[6:0], r_ir[14:12], r_ir[31:25]);

  always_comb begin
    case (w_ins)
      INS_SW:           w_imm_sel = IMM_S;
      INS_BEQ, INS_BNE: w_imm_sel = IMM_B;
      default:          w_imm_sel = IMM_I;
    endcase
  end

  imm_gen #(
    .D_WIDTH(D_WIDTH)
  ) u_imm_gen (
    .ir_hi(r_ir[31:20]),
    .ir_lo(r_ir[11:7]),
    .sel  (w_imm_sel),
    .imm  (w_imm)
  );

  assign w_active = (r_state == DECODE) || (r_state == EXEC) ||
                    (r_state == MEM)    || (r_state == WB);

  // Outputs are decoded from state/IR only; the async reset forces FETCH with
  // IR = 0, so everything except instr_ready is already zero during reset.
  always_comb begin
    instr_ready = (r_state == FETCH) && !rst;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    rs1         = '0;
    rs2         = '0;
    rd          = '0;
    reg_write   = 1'b0;
    wb_sel      = 1'b0;
    alu_src     = 1'b0;
    alu_ctrl    = ALU_ADD;
    imm_op      = '0;
    pc_en       = 1'b0;
    pc_src      = 1'b0;

    if (w_active) begin
      rs1    = A_WIDTH'(r_ir[19:15]);
      rs2    = A_WIDTH'(r_ir[24:20]);
      rd     = A_WIDTH'(r_ir[11:7]);
      imm_op = w_imm;
    end

    case (r_state)
      EXEC: begin
        case (w_ins)
          INS_ADDI, INS_LW, INS_SW: begin
            alu_src  = 1'b1;
            alu_ctrl = ALU_ADD;
          end
          INS_SUB: alu_ctrl = ALU_SUB;
          INS_AND: alu_ctrl = ALU_AND;
          INS_OR:  alu_ctrl = ALU_OR;
          INS_BEQ: begin
            alu_ctrl = ALU_SUB;
            pc_en    = 1'b1;
            pc_src   = eq;
          end
          INS_BNE: begin
            alu_ctrl = ALU_SUB;
            pc_en    = 1'b1;
            pc_src   = !eq;
          end
          default: alu_ctrl = ALU_ADD;
        endcase
      end
      MEM: begin
        mem_req = 1'b1;
        mem_we  = (w_ins == INS_SW);
        // A store retires in the ack cycle; a load retires later in WB.
        pc_en   = mem_ack && (w_ins == INS_SW);
      end
      WB: begin
        reg_write = (rd != '0);
        wb_sel    = (w_ins == INS_LW);
        pc_en     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= FETCH;
      r_ir      <= '0;
      r_cnt     <= '0;
      r_instret <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (pc_en) r_instret <= r_instret + 32'd1;

      case (r_state)
        FETCH: begin
          if (instr_valid) begin
            r_ir    <= instr;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          if (w_ins == INS_ILL) begin
            r_state   <= TRAP;
            r_illegal <= 1'b1;
          end else begin
            r_state <= EXEC;
          end
        end
        EXEC: begin
          r_cnt <= '0;
          case (w_ins)
            INS_BEQ, INS_BNE: r_state <= FETCH;
            INS_LW, INS_SW:   r_state <= MEM;
            default:          r_state <= WB;
          endcase
        end
        MEM: begin
          if (mem_ack) begin
            r_cnt   <= '0;
            r_state <= (w_ins == INS_SW) ? FETCH : WB;
          end else if (int'(r_cnt) + 1 >= MEM_TIMEOUT) begin
            r_cnt     <= r_cnt + CW'(1);
            r_state   <= TRAP;
            r_illegal <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        WB:      r_state <= FETCH;
        TRAP:    r_state <= TRAP;
        default: r_state <= FETCH;
      endcase
    end
  end

  assign illegal = r_illegal;
  assign instret = r_instret;

endmodule
`default_nettype wire
